// File: rtl/muldiv_exec_unit.sv
`timescale 1ns/1ps
// muldiv_exec_unit: multi-cycle RV32M execute unit sitting beside the EX-stage ALU.
// Radix-2 restoring divider and shift-add multiplier share one accumulator pair.
// Optional feature macro: FAST_MUL_EN (single-cycle multiply through FIN).
module muldiv_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [4:0]       ALU_Selection,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10011;
  localparam logic [4:0] OP_MULHU  = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10101;
  localparam logic [4:0] OP_DIVU   = 5'b10110;
  localparam logic [4:0] OP_REM    = 5'b10111;
  localparam logic [4:0] OP_REMU   = 5'b11000;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_special;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_legal;
  logic               w_is_mul;
  logic               w_is_rem;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div_zero;
  logic               w_overflow;
  logic               w_special;
  logic [WIDTH-1:0]   w_spec_val;
  logic               w_fast;
  logic               w_accept;
  logic               w_r_is_mul;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_fin_val;

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

`ifdef FAST_MUL_EN
  assign w_fast = w_is_mul;
  assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
`else
  assign w_fast = 1'b0;
  assign w_prod = {r_hi, r_lo};
`endif

  // Decode the incoming op: legality, signedness, magnitudes and the two short-cut cases
  always_comb begin
    w_legal    = 1'b0;
    w_is_mul   = 1'b0;
    w_is_rem   = 1'b0;
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (ALU_Selection)
      OP_MUL, OP_MULH: begin
        w_legal = 1'b1; w_is_mul = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1;
      end
      OP_MULHSU: begin
        w_legal = 1'b1; w_is_mul = 1'b1; w_a_signed = 1'b1;
      end
      OP_MULHU: begin
        w_legal = 1'b1; w_is_mul = 1'b1;
      end
      OP_DIV: begin
        w_legal = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1;
      end
      OP_DIVU: w_legal = 1'b1;
      OP_REM: begin
        w_legal = 1'b1; w_is_rem = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1;
      end
      OP_REMU: begin
        w_legal = 1'b1; w_is_rem = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    w_a_neg    = w_a_signed & A[WIDTH-1];
    w_b_neg    = w_b_signed & B[WIDTH-1];
    w_a_mag    = w_a_neg ? (~A + 1'b1) : A;
    w_b_mag    = w_b_neg ? (~B + 1'b1) : B;
    w_div_zero = w_legal & ~w_is_mul & (B == '0);
    w_overflow = ((ALU_Selection == OP_DIV) || (ALU_Selection == OP_REM)) &&
                 (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
    w_special  = w_div_zero | w_overflow;
    if (w_div_zero)
      w_spec_val = w_is_rem ? A : '1;
    else
      w_spec_val = w_is_rem ? '0 : A;
    w_accept   = (r_state == S_IDLE) && start && !kill && w_legal;
  end

  // One iteration step of the shared shift-add / restoring-subtract datapath
  always_comb begin
    w_r_is_mul  = (r_op == OP_MUL) || (r_op == OP_MULH) ||
                  (r_op == OP_MULHSU) || (r_op == OP_MULHU);
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge        = (w_div_shift >= {1'b0, r_b});
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;
  end

  // Restore signs on the unsigned results and pick the architectural result
  always_comb begin
    w_prod_s = (r_a_neg ^ r_b_neg) ? (~w_prod + 1'b1) : w_prod;
    w_quot_s = (r_a_neg ^ r_b_neg) ? (~r_lo + 1'b1) : r_lo;
    w_rem_s  = r_a_neg ? (~r_hi + 1'b1) : r_hi;
    case (r_op)
      OP_MUL:                        w_fin_val = w_prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fin_val = w_prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               w_fin_val = w_quot_s;
      default:                       w_fin_val = w_rem_s;
    endcase
    if (r_special)
      w_fin_val = r_hi;
  end

  // Control FSM and datapath registers; kill aborts without touching the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_special <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= ALU_Selection;
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_a_neg   <= w_a_neg;
            r_b_neg   <= w_b_neg;
            r_special <= w_special;
            r_hi      <= w_special ? w_spec_val : '0;
            r_lo      <= w_is_mul ? w_b_mag : w_a_mag;
            r_cnt     <= '0;
            r_state   <= (w_special || w_fast) ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            if (w_r_is_mul) begin
              r_hi <= w_mul_sum[WIDTH:1];
              r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end else begin
              r_hi <= w_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST)
              r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          if (!kill) begin
            r_result <= w_fin_val;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
`timescale 1ns/1ps
// tb_muldiv_exec_unit: directed table, randomized ops against a plain-arithmetic model,
// and hand-written sequences for start-while-busy, kill, reset and illegal codes.
module tb_muldiv_exec_unit;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10011;
  localparam logic [4:0] OP_MULHU  = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10101;
  localparam logic [4:0] OP_DIVU   = 5'b10110;
  localparam logic [4:0] OP_REM    = 5'b10111;
  localparam logic [4:0] OP_REMU   = 5'b11000;
  localparam int NVEC = 14;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [4:0]  ALU_Selection;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks;
  int          errors;
  logic [31:0] lastResult;
  vec_t        vecs[NVEC];
  logic [4:0]  legalOps[8];

  muldiv_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .ALU_Selection(ALU_Selection), .A(A), .B(B),
    .busy(busy), .done(done), .result(result)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result straight from the RV32M arithmetic rules
  function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] xa;
    logic signed [65:0] xb;
    logic signed [65:0] p;
    int sa;
    int sb;
    xa = (op == OP_MUL || op == OP_MULH || op == OP_MULHSU) ? {{34{a[31]}}, a} : {34'b0, a};
    xb = (op == OP_MUL || op == OP_MULH) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = xa * xb;
    sa = a;
    sb = b;
    case (op)
      OP_MUL: return p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Expected start-to-done distance in clock edges
  function automatic int refLatency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit isMul;
    isMul = (op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_MULHU);
    if (!isMul && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef FAST_MUL_EN
    if (isMul) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Present one op for a single edge, then scramble the operand inputs
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALU_Selection = op;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic waitDone(input int maxCyc, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < maxCyc && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic noDone(input int cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checkOutput({name, " no done"}, {31'b0, seen}, 32'd0);
  endtask

  task automatic runOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat, input string name);
    int  n;
    bit  got;
    applyStimulus(op, a, b);
    checkOutput({name, " busy after accept"}, {31'b0, busy}, 32'd1);
    waitDone(100, n, got);
    checkOutput({name, " done seen"}, {31'b0, got}, 32'd1);
    checkOutput({name, " latency"}, n, expLat);
    checkOutput({name, " result"}, result, expRes);
    @(posedge clk);
    #1;
    checkOutput({name, " done pulse"}, {31'b0, done}, 32'd0);
    checkOutput({name, " idle busy"}, {31'b0, busy}, 32'd0);
    lastResult = expRes;
  endtask

  initial begin
    int  n;
    bit  got;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    checks = 0;
    errors = 0;
    lastResult = 32'h0;
    legalOps = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    vecs[0]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[1]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[2]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[3]  = '{OP_REMU,   32'd100,      32'd7,        32'd2};
    vecs[4]  = '{OP_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF};
    vecs[5]  = '{OP_REMU,   32'h1234,     32'd0,        32'h1234};
    vecs[6]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[7]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[9]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[10] = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[12] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[13] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1};

    rst = 1'b1;
    start = 1'b0;
    kill = 1'b0;
    ALU_Selection = 5'b0;
    A = 32'h0;
    B = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
            refLatency(vecs[i].op, vecs[i].a, vecs[i].b), $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      op = legalOps[$urandom_range(0, 7)];
      a  = pickOperand();
      b  = pickOperand();
      runOp(op, a, b, refResult(op, a, b), refLatency(op, a, b),
            $sformatf("rand%0d op=%b a=%h b=%h", i, op, a, b));
    end

    runOp(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "prime");
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    ALU_Selection = OP_DIVU;
    A = 32'd1000;
    B = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(100, n, got);
    checkOutput("busy-start done seen", {31'b0, got}, 32'd1);
    checkOutput("busy-start latency", n + 5, 32'd33);
    checkOutput("busy-start result", result, 32'd14);
    lastResult = 32'd14;
    @(posedge clk);
    #1;

    applyStimulus(OP_DIVU, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill calc busy", {31'b0, busy}, 32'd0);
    noDone(40, "kill calc");
    checkOutput("kill calc result", result, lastResult);

    applyStimulus(OP_DIVU, 32'd60, 32'd6);
    repeat (32) @(posedge clk);
    #1;
    checkOutput("kill fin busy before", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill fin busy", {31'b0, busy}, 32'd0);
    checkOutput("kill fin done", {31'b0, done}, 32'd0);
    noDone(40, "kill fin");
    checkOutput("kill fin result", result, lastResult);

    @(negedge clk);
    ALU_Selection = OP_DIVU;
    A = 32'd9;
    B = 32'd3;
    start = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill = 1'b0;
    checkOutput("kill idle busy", {31'b0, busy}, 32'd0);
    noDone(40, "kill idle");
    checkOutput("kill idle result", result, lastResult);

    applyStimulus(OP_DIV, 32'hFFFFFF9C, 32'd3);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid reset busy", {31'b0, busy}, 32'd0);
    checkOutput("mid reset done", {31'b0, done}, 32'd0);
    checkOutput("mid reset result", result, 32'h0);
    rst = 1'b0;
    lastResult = 32'h0;
    runOp(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "after reset");

    applyStimulus(5'b10010, 32'd9, 32'd3);
    checkOutput("illegal 10010 busy", {31'b0, busy}, 32'd0);
    noDone(40, "illegal 10010");
    checkOutput("illegal 10010 result", result, lastResult);
    applyStimulus(5'b00000, 32'd9, 32'd3);
    checkOutput("illegal 00000 busy", {31'b0, busy}, 32'd0);
    noDone(40, "illegal 00000");
    checkOutput("illegal 00000 result", result, lastResult);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
